// File: rtl/vram_write_sched.sv
// rtl/vram_write_sched.sv - VRAM port A write scheduler: fill engine and CPU write channel sharing one port
module vram_write_sched #(
  parameter int         AW        = 10,
  parameter int         DEPTH     = 1024,
  parameter logic [7:0] PAT_MASK  = 8'h7F,
  parameter bit         BOOT_FILL = 1'b1
) (
  input  logic          MEMORY_CLK,
  input  logic          rst,
  input  logic          fill_start,
  input  logic          fill_mode,
  input  logic [7:0]    fill_char,
  input  logic          cpu_valid,
  output logic          cpu_ready,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_data,
  output logic          busy,
  output logic          fill_done,
  output logic          v_cea,
  output logic [AW-1:0] v_ada,
  output logic [7:0]    v_din
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

  state_t        state, state_nx;
  logic          turn_cpu, turn_cpu_nx;
  logic          init, init_nx;
  logic [AW:0]   idx, idx_nx;
  logic          mode, mode_nx;
  logic [7:0]    chr, chr_nx;
  logic          v_cea_nx, fill_done_nx;
  logic [AW-1:0] v_ada_nx;
  logic [7:0]    v_din_nx;

  always_ff @(posedge MEMORY_CLK) begin
    if (rst) begin
      state     <= IDLE;
      turn_cpu  <= 1'b0;
      init      <= 1'b1;
      idx       <= '0;
      mode      <= 1'b0;
      chr       <= 8'h00;
      v_cea     <= 1'b0;
      v_ada     <= '0;
      v_din     <= 8'h00;
      fill_done <= 1'b0;
    end else begin
      state     <= state_nx;
      turn_cpu  <= turn_cpu_nx;
      init      <= init_nx;
      idx       <= idx_nx;
      mode      <= mode_nx;
      chr       <= chr_nx;
      v_cea     <= v_cea_nx;
      v_ada     <= v_ada_nx;
      v_din     <= v_din_nx;
      fill_done <= fill_done_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    turn_cpu_nx  = turn_cpu;
    init_nx      = 1'b0;
    idx_nx       = idx;
    mode_nx      = mode;
    chr_nx       = chr;
    v_cea_nx     = 1'b0;
    v_ada_nx     = v_ada;
    v_din_nx     = v_din;
    fill_done_nx = 1'b0;
    busy         = (state == FILL);
    cpu_ready    = 1'b0;
    case (state)
      IDLE: begin
        // The first cycle out of reset is reserved for the optional boot fill.
        cpu_ready = !init;
        if (init) begin
          if (BOOT_FILL) begin
            state_nx    = FILL;
            idx_nx      = '0;
            turn_cpu_nx = 1'b0;
            mode_nx     = 1'b1;
            chr_nx      = 8'h00;
          end
        end else begin
          if (cpu_valid) begin
            v_cea_nx = 1'b1;
            v_ada_nx = cpu_addr;
            v_din_nx = cpu_data;
          end
          if (fill_start) begin
            state_nx    = FILL;
            idx_nx      = '0;
            turn_cpu_nx = 1'b0;
            mode_nx     = fill_mode;
            chr_nx      = fill_char;
          end
        end
      end
      FILL: begin
        cpu_ready = turn_cpu;
        if (turn_cpu && cpu_valid) begin
          v_cea_nx    = 1'b1;
          v_ada_nx    = cpu_addr;
          v_din_nx    = cpu_data;
          turn_cpu_nx = 1'b0;
        end else begin
          v_cea_nx    = 1'b1;
          v_ada_nx    = idx[AW-1:0];
          v_din_nx    = mode ? ((chr + 8'(idx)) & PAT_MASK) : chr;
          idx_nx      = idx + 1'b1;
          turn_cpu_nx = 1'b1;
          if (idx == LAST_IDX) begin
            state_nx     = IDLE;
            fill_done_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vram_write_sched.sv
// tb/tb_vram_write_sched.sv - directed self-checking bench for vram_write_sched
module tb_vram_write_sched;

  logic       MEMORY_CLK = 1'b0;
  logic       rst = 1'b1;
  logic       fill_start = 1'b0;
  logic       fill_mode = 1'b0;
  logic [7:0] fill_char = 8'h00;
  logic       cpu_valid = 1'b0;
  logic       cpu_ready;
  logic [9:0] cpu_addr = 10'h000;
  logic [7:0] cpu_data = 8'h00;
  logic       busy;
  logic       fill_done;
  logic       v_cea;
  logic [9:0] v_ada;
  logic [7:0] v_din;

  int compared = 0;
  int mismatched = 0;

  vram_write_sched #(.AW(10), .DEPTH(1024), .PAT_MASK(8'h7F), .BOOT_FILL(1'b1)) dut (
    .MEMORY_CLK(MEMORY_CLK), .rst(rst), .fill_start(fill_start), .fill_mode(fill_mode),
    .fill_char(fill_char), .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .busy(busy), .fill_done(fill_done), .v_cea(v_cea), .v_ada(v_ada),
    .v_din(v_din)
  );

  always #5 MEMORY_CLK = ~MEMORY_CLK;

  task automatic tick();
    @(posedge MEMORY_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_write(input string tag, input int a, input int d, input int fd);
    chk({tag, ".cea"}, int'(v_cea), 1);
    chk({tag, ".ada"}, int'(v_ada), a);
    chk({tag, ".din"}, int'(v_din), d);
    chk({tag, ".done"}, int'(fill_done), fd);
  endtask

  initial begin
    int bad;
    int dones;

    // reset state
    tick();
    tick();
    chk("rst.cea", int'(v_cea), 0);
    chk("rst.ada", int'(v_ada), 0);
    chk("rst.din", int'(v_din), 0);
    chk("rst.done", int'(fill_done), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.ready", int'(cpu_ready), 0);

    // 1. boot fill: 1024 incrementing writes, data = addr & 0x7F
    rst = 1'b0;
    tick();
    chk("boot.busy", int'(busy), 1);
    bad = 0;
    dones = 0;
    for (int i = 0; i < 1024; i++) begin
      tick();
      if (i == 0) chk_write("boot.first", 0, 0, 0);
      if (i == 1023) chk_write("boot.last", 1023, 8'h7F, 1);
      if (v_cea !== 1'b1 || v_ada !== 10'(i) || v_din !== 8'(i & 8'h7F)) bad++;
      if (fill_done === 1'b1) dones++;
    end
    chk("boot.bad_writes", bad, 0);
    chk("boot.done_count", dones, 1);
    chk("boot.busy_after", int'(busy), 0);
    chk("boot.ready_after", int'(cpu_ready), 1);

    // 2. CPU writes in IDLE, one per cycle, 1-cycle latency
    cpu_valid = 1'b1; cpu_addr = 10'h010; cpu_data = 8'h41;
    tick();
    chk_write("cpu0", 10'h010, 8'h41, 0);
    cpu_addr = 10'h011; cpu_data = 8'h42;
    tick();
    chk_write("cpu1", 10'h011, 8'h42, 0);
    cpu_addr = 10'h3FF; cpu_data = 8'h43;
    tick();
    chk_write("cpu2", 10'h3FF, 8'h43, 0);
    cpu_valid = 1'b0;
    tick();
    chk("cpu.idle_cea", int'(v_cea), 0);
    chk("cpu.hold_ada", int'(v_ada), 10'h3FF);
    chk("cpu.hold_din", int'(v_din), 8'h43);

    // 3. contention: constant fill 0x20 against a continuously valid CPU
    fill_start = 1'b1; fill_mode = 1'b0; fill_char = 8'h20;
    cpu_valid = 1'b1; cpu_addr = 10'h005; cpu_data = 8'h58;
    tick();
    fill_start = 1'b0;
    chk_write("cont.cpu_first", 10'h005, 8'h58, 0);
    bad = 0;
    dones = 0;
    for (int t = 2; t <= 2048; t++) begin
      tick();
      if (t % 2 == 0) begin
        if (v_cea !== 1'b1 || v_ada !== 10'((t - 2) / 2) || v_din !== 8'h20) bad++;
      end else begin
        if (v_cea !== 1'b1 || v_ada !== 10'h005 || v_din !== 8'h58) bad++;
      end
      if (fill_done === 1'b1) dones++;
      if (t == 2048) chk_write("cont.last_fill", 1023, 8'h20, 1);
    end
    cpu_valid = 1'b0;
    chk("cont.bad_writes", bad, 0);
    chk("cont.done_count", dones, 1);
    chk("cont.busy_after", int'(busy), 0);

    // 4. pattern wrap with base 0x7E, and 5. ignored fill_start at idx 100
    fill_start = 1'b1; fill_mode = 1'b1; fill_char = 8'h7E;
    tick();
    fill_start = 1'b0;
    tick();
    chk_write("wrap.idx0", 0, 8'h7E, 0);
    tick();
    chk_write("wrap.idx1", 1, 8'h7F, 0);
    tick();
    chk_write("wrap.idx2", 2, 8'h00, 0);
    bad = 0;
    dones = 0;
    for (int i = 3; i < 1024; i++) begin
      if (i == 100) begin
        fill_start = 1'b1; fill_mode = 1'b0; fill_char = 8'h55;
      end
      tick();
      fill_start = 1'b0;
      if (v_cea !== 1'b1 || v_ada !== 10'(i) || v_din !== 8'((8'h7E + i) & 8'h7F)) bad++;
      if (fill_done === 1'b1) dones++;
    end
    chk("ign.bad_writes", bad, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (fill_done === 1'b1 || v_cea === 1'b1) dones++;
    end
    chk("ign.done_count", dones, 1);
    chk("ign.busy_after", int'(busy), 0);

    // 6. reset in the cycle that would issue idx 500
    fill_start = 1'b1; fill_mode = 1'b1; fill_char = 8'h00;
    tick();
    fill_start = 1'b0;
    dones = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (fill_done === 1'b1) dones++;
    end
    chk("rstmid.pre_ada", int'(v_ada), 499);
    rst = 1'b1;
    tick();
    chk("rstmid.cea", int'(v_cea), 0);
    chk("rstmid.busy", int'(busy), 0);
    chk("rstmid.done", int'(fill_done), 0);
    chk("rstmid.done_count", dones, 0);
    rst = 1'b0;
    tick();
    tick();
    chk_write("rstmid.restart", 0, 0, 0);
    chk("rstmid.busy_restart", int'(busy), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
